// File: rtl/pp_line_splicer.sv
// pp_line_splicer: strips backslash-newline continuations and `` paste pairs from a byte stream.
module pp_line_splicer #(
  parameter bit PASTE_EN = 1'b1,
  parameter bit CRLF_EN  = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_keep,
  output logic             out_last,
  output logic [CNT_W-1:0] splice_count,
  output logic [CNT_W-1:0] paste_count
);
  localparam logic [7:0] BS = 8'h5C;
  localparam logic [7:0] BT = 8'h60;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  typedef enum logic [1:0] {S_PASS, S_BS, S_BSCR, S_BT} state_t;
  state_t st_q, st_d;
  logic [9:0] fifo_q [3];
  logic [9:0] fifo_d [3];
  logic [1:0] cnt_q, cnt_d, pn;
  logic [CNT_W-1:0] spl_q, spl_d, pst_q, pst_d;
  logic acc, pop, cls;
  assign in_ready = !rst && (cnt_q == 2'd0 || (cnt_q == 2'd1 && out_ready));
  assign acc = in_valid && in_ready;
  assign out_valid = cnt_q != 2'd0;
  assign pop = out_valid && out_ready;
  assign {out_last, out_keep, out_data} = fifo_q[0];
  assign splice_count = spl_q;
  assign paste_count = pst_q;
  // An accept only happens when the FIFO drains this cycle, so a beat rewrites it from slot 0.
  always_comb begin
    fifo_d = fifo_q;
    cnt_d = cnt_q;
    st_d = st_q;
    spl_d = spl_q;
    pst_d = pst_q;
    pn = 2'd0;
    cls = 1'b1;
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      fifo_d[1] = fifo_q[2];
      fifo_d[2] = '0;
      cnt_d = cnt_q - 2'd1;
    end
    if (acc) begin
      fifo_d = '{default: '0};
      if (in_data == LF && (st_q == S_BS || st_q == S_BSCR)) begin
        cls = 1'b0;
        st_d = S_PASS;
        spl_d = &spl_q ? spl_q : spl_q + 1'b1;
      end else if (st_q == S_BT && in_data == BT) begin
        cls = 1'b0;
        st_d = S_PASS;
        pst_d = &pst_q ? pst_q : pst_q + 1'b1;
      end else if (st_q == S_BS && in_data == CR && CRLF_EN) begin
        cls = 1'b0;
        st_d = S_BSCR;
      end else if (st_q != S_PASS) begin
        fifo_d[0] = {2'b01, st_q == S_BT ? BT : BS};
        fifo_d[1] = st_q == S_BSCR ? {2'b01, CR} : 10'h000;
        pn = st_q == S_BSCR ? 2'd2 : 2'd1;
      end
      if (cls) begin
        st_d = in_data == BS ? S_BS : (in_data == BT && PASTE_EN) ? S_BT : S_PASS;
        if (st_d == S_PASS) begin
          fifo_d[pn] = {2'b01, in_data};
          pn = pn + 2'd1;
        end
      end
      if (in_last) begin
        if (st_d != S_PASS) begin
          fifo_d[pn] = {2'b01, st_d == S_BT ? BT : BS};
          pn = pn + 2'd1;
        end
        if (st_d == S_BSCR) begin
          fifo_d[pn] = {2'b01, CR};
          pn = pn + 2'd1;
        end
        st_d = S_PASS;
        if (pn == 2'd0) begin
          fifo_d[0] = 10'h200;
          pn = 2'd1;
        end else fifo_d[pn - 2'd1][9] = 1'b1;
      end
      cnt_d = pn;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= S_PASS;
      cnt_q <= 2'd0;
      spl_q <= '0;
      pst_q <= '0;
      fifo_q <= '{default: '0};
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      spl_q <= spl_d;
      pst_q <= pst_d;
      fifo_q <= fifo_d;
    end
  end
endmodule

// File: tb/tb_pp_line_splicer.sv
// tb_pp_line_splicer: directed vector table plus corner sequences and a throttled random stream.
module tb_pp_line_splicer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [2:0] iv = '0, il = '0, ordy = '1;
  logic [7:0] id [3];
  wire [2:0] ir, ov, ok, ol;
  wire [7:0] od [3];
  wire [15:0] sc [3];
  wire [15:0] pc [3];
  // Instance 0: defaults, 1: paste stripping off, 2: 4-bit counters.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = g == 2 ? 4 : 16;
    wire [W-1:0] s, p;
    pp_line_splicer #(.PASTE_EN(1'(g != 1)), .CRLF_EN(1'b1), .CNT_W(W)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]), .in_data(id[g]),
      .in_last(il[g]), .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(od[g]),
      .out_keep(ok[g]), .out_last(ol[g]), .splice_count(s), .paste_count(p));
    assign sc[g] = 16'(s);
    assign pc[g] = 16'(p);
  end
  typedef struct {
    string si;
    string se;
    bit    term;
    int    spl;
    int    pst;
    int    k;
  } vec_t;
  vec_t tv[15];
  int n_chk = 0, n_fail = 0, cur = 0;
  bit rnd_on = 1'b0;
  logic [9:0] got[$];
  logic [9:0] exq[$];
  logic [7:0] rin[$];
  logic stall_q = 1'b0;
  logic [9:0] hold_q = '0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    ordy = (rnd_on && $urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_q) chk("stall_hold", {ov[cur], ol[cur], ok[cur], od[cur]}, {1'b1, hold_q});
      if (ov[cur] && ordy[cur]) got.push_back({ol[cur], ok[cur], od[cur]});
      stall_q <= ov[cur] && !ordy[cur];
      hold_q <= {ol[cur], ok[cur], od[cur]};
    end else stall_q <= 1'b0;
  end
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got.delete();
  endtask
  task automatic send(int k, logic [7:0] d, logic l);
    int t = 0;
    id[k] = d;
    il[k] = l;
    iv[k] = 1'b1;
    @(negedge clk);
    while (!ir[k] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("send_accept", 32'(ir[k]), 1);
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    il[k] = 1'b0;
  endtask
  task automatic drain(int k);
    int t = 0;
    while (ov[k] && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(ov[k]), 0);
  endtask
  task automatic build_exp(string e, bit term);
    exq.delete();
    for (int i = 0; i < e.len(); i++) exq.push_back({i == e.len() - 1 && !term, 1'b1, e[i]});
    if (term) exq.push_back(10'h200);
  endtask
  task automatic cmp_q(string nm);
    chk({nm, "_len"}, got.size(), exq.size());
    for (int i = 0; i < exq.size() && i < got.size(); i++) chk({nm, "_beat"}, 32'(got[i]), 32'(exq[i]));
  endtask
  task automatic run_vec(int n, vec_t v);
    do_reset();
    cur = v.k;
    for (int j = 0; j < v.si.len(); j++) send(v.k, v.si[j], j == v.si.len() - 1);
    drain(v.k);
    build_exp(v.se, v.term);
    cmp_q($sformatf("vec%0d", n));
    chk($sformatf("vec%0d_splice", n), 32'(sc[v.k]), v.spl);
    chk($sformatf("vec%0d_paste", n), 32'(pc[v.k]), v.pst);
  endtask
  task automatic model(output int ns, output int np);
    int i = 0;
    int n = rin.size();
    bit dropped = 1'b0;
    logic [9:0] tmp;
    exq.delete();
    ns = 0;
    np = 0;
    while (i < n) begin
      dropped = 1'b1;
      if (rin[i] == 8'h5C && i + 1 < n && rin[i+1] == 8'h0A) begin ns++; i += 2; end
      else if (rin[i] == 8'h5C && i + 2 < n && rin[i+1] == 8'h0D && rin[i+2] == 8'h0A) begin ns++; i += 3; end
      else if (rin[i] == 8'h60 && i + 1 < n && rin[i+1] == 8'h60) begin np++; i += 2; end
      else begin
        exq.push_back({2'b01, rin[i]});
        i++;
        dropped = 1'b0;
      end
    end
    if (dropped) exq.push_back(10'h200);
    else begin
      tmp = exq.pop_back();
      tmp[9] = 1'b1;
      exq.push_back(tmp);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [7:0] alph [5];
    int ns, np;
    alph = '{8'h61, 8'h5C, 8'h60, 8'h0D, 8'h0A};
    tv[0]  = '{"a\\\nb", "ab", 1'b0, 1, 0, 0};
    tv[1]  = '{"x\140\140y", "xy", 1'b0, 0, 1, 0};
    tv[2]  = '{"\\\015\n\\\015q", "\\\015q", 1'b0, 1, 0, 0};
    tv[3]  = '{"a\\\n", "a", 1'b1, 1, 0, 0};
    tv[4]  = '{"z\\", "z\\", 1'b0, 0, 0, 0};
    tv[5]  = '{"\\\\\n", "\\", 1'b1, 1, 0, 0};
    tv[6]  = '{"\140\140\140", "\140", 1'b0, 0, 1, 0};
    tv[7]  = '{"\\\015", "\\\015", 1'b0, 0, 0, 0};
    tv[8]  = '{"\140a", "\140a", 1'b0, 0, 0, 0};
    tv[9]  = '{"\015\n", "\015\n", 1'b0, 0, 0, 0};
    tv[10] = '{"\\\140", "\\\140", 1'b0, 0, 0, 0};
    tv[11] = '{"\140\140", "", 1'b1, 0, 1, 0};
    tv[12] = '{"x\140\140y", "x\140\140y", 1'b0, 0, 0, 1};
    tv[13] = '{"\\\n", "", 1'b1, 1, 0, 1};
    tv[14] = '{"\\\015\\\n", "\\\015", 1'b1, 1, 0, 0};
    for (int k = 0; k < 3; k++) id[k] = 8'h00;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(ir[0]), 0);
    do_reset();
    chk("rst_state", {ov[0], ok[0], ol[0], od[0]}, 0);
    chk("rst_splice", 32'(sc[0]), 0);
    chk("rst_paste", 32'(pc[0]), 0);
    for (int n = 0; n < 15; n++) run_vec(n, tv[n]);
    do_reset();
    cur = 0;
    send(0, 8'h61, 1'b0);
    send(0, 8'h5C, 1'b0);
    send(0, 8'h0A, 1'b0);
    send(0, 8'h62, 1'b1);
    chk("lat_valid", 32'(ov[0]), 1);
    chk("lat_data", 32'(od[0]), 32'h62);
    drain(0);
    build_exp("ab", 1'b0);
    cmp_q("lat");
    do_reset();
    cur = 0;
    send(0, 8'h5C, 1'b0);
    send(0, 8'h0D, 1'b0);
    send(0, 8'h0A, 1'b0);
    send(0, 8'h5C, 1'b0);
    send(0, 8'h0D, 1'b0);
    send(0, 8'h71, 1'b1);
    chk("backlog_ready0", 32'(ir[0]), 0);
    @(posedge clk);
    #1;
    chk("backlog_ready1", 32'(ir[0]), 0);
    @(posedge clk);
    #1;
    chk("backlog_ready2", 32'(ir[0]), 1);
    drain(0);
    build_exp("\\\015q", 1'b0);
    cmp_q("backlog");
    chk("backlog_splice", 32'(sc[0]), 1);
    do_reset();
    cur = 2;
    for (int j = 0; j < 20; j++) begin
      send(2, 8'h5C, 1'b0);
      send(2, 8'h0A, j == 19);
    end
    drain(2);
    build_exp("", 1'b1);
    cmp_q("sat");
    chk("sat_splice", 32'(sc[2]), 15);
    send(2, 8'h5C, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(ov[2]), 0);
    chk("midrst_splice", 32'(sc[2]), 0);
    rst = 1'b0;
    got.delete();
    send(2, 8'h62, 1'b1);
    drain(2);
    build_exp("b", 1'b0);
    cmp_q("midrst");
    do_reset();
    cur = 0;
    rin.delete();
    for (int j = 0; j < 1000; j++) rin.push_back(alph[$urandom_range(0, 4)]);
    rnd_on = 1'b1;
    for (int j = 0; j < 1000; j++) send(0, rin[j], j == 999);
    drain(0);
    rnd_on = 1'b0;
    model(ns, np);
    cmp_q("rand");
    chk("rand_splice", 32'(sc[0]), ns);
    chk("rand_paste", 32'(pc[0]), np);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
